notif_collector: RTL and testbench
==================================

Name: notif_collector

Overview:
- Upstream stage of the 8:1 notification mux.
- Captures single-cycle per-app notification events into sticky pending flags with saturating per-app counters. pend_o drives the mux data input a.
- A round-robin scanner FSM offers each pending app index on sel_o, which drives the mux select s, using a valid/ready handshake to the display consumer.
- Accepting an offer clears that app's pending state.

Parameters:
- N_APPS, 8, number of app channels; fixed to 8 for mux compatibility.
- SEL_W, 3, select width; must equal clog2(N_APPS).
- CNT_W, 4, width of each per-app event counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- evt_i  in  N_APPS  one-cycle event pulses; bit k = app k (0 WhatsApp, 1 LinkedIn, 2 Gmail, 3 SMS, 4 YouTube, 5 Facebook, 6 Calendar, 7 Calls).
- clr_all_i  in  1  synchronous clear of all pending state.
- pend_o  out  N_APPS  registered pending flags; connects to mux a.
- sel_o  out  SEL_W  offered app index; connects to mux s.
- sel_valid_o  out  1  sel_o and cnt_o are valid.
- sel_ready_i  in  1  consumer accepts the current offer.
- cnt_o  out  CNT_W  event count of the app on sel_o.
- ovf_o  out  N_APPS  sticky per-app counter-saturation flags.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: pend_o=0, ovf_o=0, all counters=0, sel_o=0, sel_valid_o=0, cnt_o=0, rr pointer=0, state=IDLE.
- Reset asserted mid-offer aborts the offer immediately.
- Event capture, per app k, each cycle:
  - evt_i[k]=1 sets pend[k] on the next edge.
  - It also increments cnt[k], saturating at 2^CNT_W-1.
  - An event arriving while cnt[k] is saturated sets ovf[k].
- Accept: a handshake occurs when sel_valid_o & sel_ready_i. On accept:
  - pend, cnt and ovf of app sel_o clear on the next edge.
  - If evt_i[sel_o]=1 in the accept cycle, pend stays 1, cnt=1 and ovf=0 (the new event is not lost).
- clr_all_i=1 has the highest priority below reset:
  - Clears all pend, cnt and ovf; events in the same cycle are dropped.
  - Forces state to IDLE; sel_valid_o=0 next cycle; the pointer is unchanged.
- FSM states IDLE and OFFER:
  - IDLE: if pend_o!=0, pick the first pending index at or after ptr, wrapping 7->0. Register it into sel_o, set sel_valid_o=1, go to OFFER. Otherwise stay in IDLE.
  - OFFER: hold sel_o stable while sel_valid_o=1 and sel_ready_i=0. cnt_o tracks cnt[sel_o] live, so further events on the offered app increment it.
  - OFFER on accept: ptr = sel_o+1 mod N_APPS, sel_valid_o=0, go to IDLE. This gives one bubble cycle between offers.
- Latency: event at edge t -> pend_o visible after t+1 -> sel_valid_o after t+2 (system idle, app reached by the pointer scan).
- sel_ready_i is ignored when sel_valid_o=0.
- Fairness: any pending app is offered within N_APPS accepts.

Optional Feature:
- Macro NOTIF_DND_EN adds input dnd_mask_i [N_APPS], do-not-disturb.
- With the macro defined:
  - Masked apps still capture events, counts and pend_o bits.
  - Masked apps are excluded from the scanner pick.
  - Masking the currently offered app does not withdraw the offer.
- Without the macro: no port; all pending apps are eligible.

Decomposition:
- Package notif_pkg holds:
  - N_APPS, SEL_W, CNT_W defaults.
  - App index constants APP_WHATSAPP..APP_CALLS (0..7).
  - State enum notif_state_t {IDLE, OFFER}.
- Sub-module notif_rr_pick: combinational rotate-priority finder.
  - Inputs: request vector, pointer.
  - Outputs: found flag, index.
  - Instantiated once in notif_collector.

Test Plan:
- Reset/idle: hold rst_n=0 and pulse evt_i; release -> all outputs 0, sel_valid_o=0 indefinitely with no events.
- Single event: evt_i=8'b00000100 for one cycle -> pend_o=8'b00000100 next cycle; sel_valid_o=1, sel_o=2, cnt_o=1 the cycle after; accept -> pend_o=0 and sel_valid_o=0 next cycle.
- Round robin and backpressure:
  - Setup: events on apps 2 and 5 together, ptr=0, sel_ready_i=0 for 5 cycles.
  - Expected: sel_o=2 held stable throughout; accept -> one bubble, then sel_o=5; accept -> IDLE.
- Saturation: 20 pulses on app 7 with CNT_W=4 -> cnt_o=15 when offered, ovf_o[7]=1; accept clears both.
- Accept plus event: accept app 3 while evt_i[3]=1 -> pend_o[3] stays 1 and app 3 is re-offered later with cnt_o=1; clr_all_i during OFFER -> pend_o=0, sel_valid_o=0 next cycle.
- NOTIF_DND_EN, dnd_mask_i=8'b00000100:
  - Stimulus: events on apps 2 and 6.
  - Expected: only sel_o=6 is offered; pend_o[2] stays 1; clearing the mask -> app 2 is offered.

Source files
------------

// File: rtl/notif_pkg.sv
// Shared constants and types for the notification collector.
// Latency: none (declarations only).
// Backpressure: not applicable.
package notif_pkg;

    localparam int N_APPS = 8;   // fixed to 8 so the downstream 8:1 mux lines up
    localparam int SEL_W  = 3;   // clog2(N_APPS)
    localparam int CNT_W  = 4;   // per-app event counter width

    localparam logic [SEL_W-1:0] APP_WHATSAPP = 3'd0;
    localparam logic [SEL_W-1:0] APP_LINKEDIN = 3'd1;
    localparam logic [SEL_W-1:0] APP_GMAIL    = 3'd2;
    localparam logic [SEL_W-1:0] APP_SMS      = 3'd3;
    localparam logic [SEL_W-1:0] APP_YOUTUBE  = 3'd4;
    localparam logic [SEL_W-1:0] APP_FACEBOOK = 3'd5;
    localparam logic [SEL_W-1:0] APP_CALENDAR = 3'd6;
    localparam logic [SEL_W-1:0] APP_CALLS    = 3'd7;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } notif_state_t;

endpackage

// File: rtl/notif_rr_pick.sv
// Rotate-priority finder: first set request at or after ptr_i, wrapping 7->0.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to use the result.
module notif_rr_pick
    import notif_pkg::*;
(
    input  logic [N_APPS-1:0] req_i,
    input  logic [SEL_W-1:0]  ptr_i,
    output logic              found_o,
    output logic [SEL_W-1:0]  idx_o
);

    logic [SEL_W-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest request wins last.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int i = N_APPS - 1; i >= 0; i--) begin
            // N_APPS is a power of two, so SEL_W-bit addition wraps naturally.
            cand = ptr_i + i[SEL_W-1:0];
            if (req_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/notif_collector.sv
// Sticky per-app pending/count/overflow capture with a round-robin offer scanner.
// Latency: event -> pend_o after 1 edge -> sel_valid_o after 2 edges when idle.
// Backpressure: offer held stable until sel_ready_i; one bubble between offers.
// Optional: define NOTIF_DND_EN to add dnd_mask_i, which hides apps from the scanner.
module notif_collector
    import notif_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_APPS-1:0] evt_i,
    input  logic              clr_all_i,
`ifdef NOTIF_DND_EN
    input  logic [N_APPS-1:0] dnd_mask_i,
`endif
    output logic [N_APPS-1:0] pend_o,
    output logic [SEL_W-1:0]  sel_o,
    output logic              sel_valid_o,
    input  logic              sel_ready_i,
    output logic [CNT_W-1:0]  cnt_o,
    output logic [N_APPS-1:0] ovf_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [N_APPS-1:0] pend_q, pend_d;
    logic [N_APPS-1:0] ovf_q, ovf_d;
    logic [CNT_W-1:0]  cnt_q [N_APPS];
    logic [CNT_W-1:0]  cnt_d [N_APPS];
    notif_state_t      state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;

    logic [N_APPS-1:0] elig;
    logic              pick_found;
    logic [SEL_W-1:0]  pick_idx;
    logic              accept;

`ifdef NOTIF_DND_EN
    // Masked apps keep capturing, they are only hidden from the scanner.
    assign elig = pend_q & ~dnd_mask_i;
`else
    assign elig = pend_q;
`endif

    assign sel_valid_o = (state_q == OFFER);
    assign accept      = sel_valid_o & sel_ready_i;

    notif_rr_pick u_pick (
        .req_i   (elig),
        .ptr_i   (ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    // Per-app capture; accept then clear-all override in increasing priority.
    always_comb begin
        pend_d = pend_q;
        ovf_d  = ovf_q;
        cnt_d  = cnt_q;
        for (int k = 0; k < N_APPS; k++) begin
            if (evt_i[k]) begin
                pend_d[k] = 1'b1;
                if (cnt_q[k] == CNT_MAX) ovf_d[k] = 1'b1;
                else                     cnt_d[k] = cnt_q[k] + CNT_ONE;
            end
        end
        if (accept) begin
            // A same-cycle event on the accepted app starts a fresh count of one.
            pend_d[sel_q] = evt_i[sel_q];
            cnt_d[sel_q]  = evt_i[sel_q] ? CNT_ONE : '0;
            ovf_d[sel_q]  = 1'b0;
        end
        if (clr_all_i) begin
            pend_d = '0;
            ovf_d  = '0;
            for (int k = 0; k < N_APPS; k++) cnt_d[k] = '0;
        end
    end

    // Scanner: pick in IDLE, hold in OFFER until accepted, then advance pointer.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        if (clr_all_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        sel_d   = pick_idx;
                        state_d = OFFER;
                    end
                end
                OFFER: begin
                    if (sel_ready_i) begin
                        ptr_d   = sel_q + 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State registers; reset aborts any offer in flight immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q  <= '0;
            ovf_q   <= '0;
            state_q <= IDLE;
            sel_q   <= '0;
            ptr_q   <= '0;
            for (int k = 0; k < N_APPS; k++) cnt_q[k] <= '0;
        end else begin
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            for (int k = 0; k < N_APPS; k++) cnt_q[k] <= cnt_d[k];
        end
    end

    assign pend_o = pend_q;
    assign ovf_o  = ovf_q;
    assign sel_o  = sel_q;
    // Live view of the offered app's counter; zero when nothing is offered.
    assign cnt_o  = sel_valid_o ? cnt_q[sel_q] : '0;

endmodule

// File: tb/tb_notif_collector.sv
// Randomised and directed bench for notif_collector against a behavioural model.
// Latency: checks every cycle one time unit after the rising edge.
// Backpressure: sel_ready_i driven directly and randomly.
module tb_notif_collector;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] evt_i = '0;
    logic       clr_all_i = 1'b0;
    logic       sel_ready_i = 1'b0;
    logic [7:0] pend_o;
    logic [2:0] sel_o;
    logic       sel_valid_o;
    logic [3:0] cnt_o;
    logic [7:0] ovf_o;
    logic [7:0] dnd = '0;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    notif_collector dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .evt_i       (evt_i),
        .clr_all_i   (clr_all_i),
`ifdef NOTIF_DND_EN
        .dnd_mask_i  (dnd),
`endif
        .pend_o      (pend_o),
        .sel_o       (sel_o),
        .sel_valid_o (sel_valid_o),
        .sel_ready_i (sel_ready_i),
        .cnt_o       (cnt_o),
        .ovf_o       (ovf_o)
    );

    // Reference model: pending set, counts as plain integers, an offer slot.
    bit [7:0] m_pend, m_ovf;
    int       m_cnt [8];
    bit       m_off;
    int       m_sel, m_ptr;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend = '0; m_ovf = '0; m_off = 0; m_sel = 0; m_ptr = 0;
        for (int k = 0; k < 8; k++) m_cnt[k] = 0;
    endtask

    task automatic check_all();
        chk("pend", int'(pend_o), int'(m_pend));
        chk("ovf", int'(ovf_o), int'(m_ovf));
        chk("vld", int'(sel_valid_o), int'(m_off));
        if (m_off) begin
            chk("sel", int'(sel_o), m_sel);
            chk("cnt", int'(cnt_o), m_cnt[m_sel]);
        end
    endtask

    // Drive one cycle, advance the model by the rules, compare after the edge.
    task automatic cycle(input bit [7:0] evt, input bit clr, input bit rdy);
        bit [7:0] n_pend, n_ovf;
        int       n_cnt [8];
        bit       n_off;
        int       n_sel, n_ptr;
        bit [7:0] elig;
        evt_i = evt; clr_all_i = clr; sel_ready_i = rdy;
        n_pend = m_pend; n_ovf = m_ovf; n_off = m_off; n_sel = m_sel; n_ptr = m_ptr;
        for (int k = 0; k < 8; k++) n_cnt[k] = m_cnt[k];
        elig = m_pend & ~dnd;
        if (clr) begin
            n_pend = '0; n_ovf = '0; n_off = 0;
            for (int k = 0; k < 8; k++) n_cnt[k] = 0;
        end else begin
            for (int k = 0; k < 8; k++) begin
                if (evt[k]) begin
                    n_pend[k] = 1;
                    if (m_cnt[k] >= 15) n_ovf[k] = 1;
                    else n_cnt[k] = m_cnt[k] + 1;
                end
            end
            if (m_off && rdy) begin
                n_pend[m_sel] = evt[m_sel];
                n_cnt[m_sel]  = evt[m_sel] ? 1 : 0;
                n_ovf[m_sel]  = 0;
                n_off = 0;
                n_ptr = (m_sel + 1) % 8;
            end else if (!m_off && elig != 0) begin
                for (int d = 7; d >= 0; d--)
                    if (elig[(m_ptr + d) % 8]) n_sel = (m_ptr + d) % 8;
                n_off = 1;
            end
        end
        @(posedge clk);
        m_pend = n_pend; m_ovf = n_ovf; m_off = n_off; m_sel = n_sel; m_ptr = n_ptr;
        for (int k = 0; k < 8; k++) m_cnt[k] = n_cnt[k];
        #1;
        check_all();
    endtask

    task automatic do_reset();
        evt_i = 8'h5a; clr_all_i = 0; sel_ready_i = 0;
        rst_n = 0;
        #1;
        model_reset();
        chk("rst_pend", int'(pend_o), 0);
        chk("rst_vld", int'(sel_valid_o), 0);
        chk("rst_cnt", int'(cnt_o), 0);
        chk("rst_sel", int'(sel_o), 0);
        chk("rst_ovf", int'(ovf_o), 0);
        @(posedge clk);
        @(negedge clk);
        evt_i = '0;
        rst_n = 1;
    endtask

    initial begin
        model_reset();
        do_reset();
        // Idle after reset: nothing is ever offered.
        for (int i = 0; i < 10; i++) cycle(8'h00, 0, 1);
        chk("idle_vld", int'(sel_valid_o), 0);

        // Single event on Gmail.
        cycle(8'h04, 0, 0);
        chk("single_pend", int'(pend_o), 8'h04);
        chk("single_vld0", int'(sel_valid_o), 0);
        cycle(8'h00, 0, 0);
        chk("single_vld", int'(sel_valid_o), 1);
        chk("single_sel", int'(sel_o), 2);
        chk("single_cnt", int'(cnt_o), 1);
        cycle(8'h00, 0, 1);
        chk("single_acc_pend", int'(pend_o), 0);
        chk("single_acc_vld", int'(sel_valid_o), 0);

        // Round robin with backpressure from ptr=0.
        do_reset();
        cycle(8'h24, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cycle(8'h00, 0, 0);
            chk("rr_hold_sel", int'(sel_o), 2);
        end
        cycle(8'h00, 0, 1);
        chk("rr_bubble", int'(sel_valid_o), 0);
        cycle(8'h00, 0, 0);
        chk("rr_second", int'(sel_o), 5);
        cycle(8'h00, 0, 1);
        cycle(8'h00, 0, 0);
        chk("rr_idle", int'(sel_valid_o), 0);

        // Saturation on Calls.
        for (int i = 0; i < 20; i++) cycle(8'h80, 0, 0);
        chk("sat_cnt", int'(cnt_o), 15);
        chk("sat_ovf", int'(ovf_o[7]), 1);
        cycle(8'h00, 0, 1);
        chk("sat_clr_ovf", int'(ovf_o), 0);
        chk("sat_clr_pend", int'(pend_o), 0);

        // Accept with a same-cycle event on SMS, then clear-all during offer.
        do_reset();
        cycle(8'h08, 0, 0);
        cycle(8'h08, 0, 0);
        cycle(8'h08, 0, 1);
        chk("ae_pend", int'(pend_o[3]), 1);
        cycle(8'h00, 0, 0);
        cycle(8'h00, 0, 0);
        chk("ae_reoffer", int'(sel_o), 3);
        chk("ae_cnt", int'(cnt_o), 1);
        cycle(8'h00, 1, 0);
        chk("clr_pend", int'(pend_o), 0);
        chk("clr_vld", int'(sel_valid_o), 0);

        // Reset asserted mid-offer aborts it without waiting for an edge.
        cycle(8'h10, 0, 0);
        cycle(8'h00, 0, 0);
        chk("mid_vld", int'(sel_valid_o), 1);
        #2;
        do_reset();

`ifdef NOTIF_DND_EN
        dnd = 8'h04;
        cycle(8'h44, 0, 0);
        cycle(8'h00, 0, 0);
        chk("dnd_sel", int'(sel_o), 6);
        cycle(8'h00, 0, 1);
        for (int i = 0; i < 4; i++) cycle(8'h00, 0, 0);
        chk("dnd_hidden", int'(sel_valid_o), 0);
        chk("dnd_pend2", int'(pend_o[2]), 1);
        dnd = 8'h00;
        cycle(8'h00, 0, 0);
        cycle(8'h00, 0, 0);
        chk("dnd_release", int'(sel_o), 2);
        cycle(8'h00, 0, 1);
`endif

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
`ifdef NOTIF_DND_EN
            if ($urandom_range(0, 15) == 0) dnd = 8'($urandom);
`endif
            cycle(($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00,
                  ($urandom_range(0, 60) == 0),
                  ($urandom_range(0, 2) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
